// File: rtl/axi_lite_write_ctrl.sv
// AXI4-Lite write-channel controller: joins independently arriving AW and W beats,
// issues a one-cycle register-file write strobe, then returns a B response.
module axi_lite_write_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                    i_clock,
    input  logic                    i_areset_n,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH-3:0]   o_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_wr_strb
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    logic                run;
    logic                aw_held;
    logic                w_held;
    logic                err;
    logic [IDX_W-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_W-1:0]   strb_q;
    logic                wr_en_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;

    logic                aw_hs;
    logic                w_hs;
    logic [IDX_W-1:0]    next_idx;
    logic                in_range;
    logic                unused_addr_lsb;

    // Ready terms come only from registers; run keeps them low through reset.
    assign o_awready = run & (state == IDLE) & ~aw_held;
    assign o_wready  = run & (state == IDLE) & ~w_held;

    assign aw_hs    = i_awvalid & o_awready;
    assign w_hs     = i_wvalid & o_wready;
    assign next_idx = aw_hs ? i_awaddr[ADDR_WIDTH-1:2] : addr_q;
    assign in_range = {1'b0, next_idx} < (IDX_W + 1)'(NUM_REGS);

    // Byte lane within the word is irrelevant: unaligned accesses hit the containing word.
    assign unused_addr_lsb = ^i_awaddr[1:0];

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = addr_q;
    assign o_wr_data = data_q;
    assign o_wr_strb = strb_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;

    always_ff @(posedge i_clock) begin
        if (!i_areset_n) begin
            state    <= IDLE;
            run      <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            err      <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            wr_en_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            run     <= 1'b1;
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= i_awaddr[ADDR_WIDTH-1:2];
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        data_q <= i_wdata;
                        strb_q <= i_wstrb;
                        w_held <= 1'b1;
                    end
                    // Both beats present (held or arriving now): commit the write.
                    if ((aw_held | aw_hs) && (w_held | w_hs)) begin
                        state   <= WRITE;
                        wr_en_q <= in_range;
                        err     <= ~in_range;
                    end
                end
                WRITE: begin
                    state    <= RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= err ? RESP_SLVERR : RESP_OKAY;
                end
                RESP: begin
                    if (i_bready) begin
                        state    <= IDLE;
                        bvalid_q <= 1'b0;
                        bresp_q  <= RESP_OKAY;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_write_ctrl.sv
// Directed bench for axi_lite_write_ctrl: inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_lite_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    int checks;
    int failures;

    axi_lite_write_ctrl #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .NUM_REGS(16)
    ) dut (
        .i_clock   (clk),
        .i_areset_n(rst_n),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_wr_strb (wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        awaddr   = '0;
        awvalid  = 1'b0;
        wdata    = '0;
        wstrb    = '0;
        wvalid   = 1'b0;
        bready   = 1'b1;

        // Reset: everything low.
        step();
        step();
        check("rst_awready", awready, 0);
        check("rst_wready",  wready,  0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_bresp",   bresp,   0);
        check("rst_wr_en",   wr_en,   0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_strb", wr_strb, 0);

        rst_n = 1'b1;
        step();
        check("rel_awready", awready, 1);
        check("rel_wready",  wready,  1);

        // AW and W in the same cycle.
        awaddr = 8'h08; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        idle_inputs();
        check("s1_wr_en",    wr_en,   1);
        check("s1_wr_addr",  wr_addr, 2);
        check("s1_wr_data",  wr_data, 32'hDEADBEEF);
        check("s1_wr_strb",  wr_strb, 4'hF);
        check("s1_awready",  awready, 0);
        check("s1_bvalid_w", bvalid,  0);
        step();
        check("s1_wr_en_off", wr_en,  0);
        check("s1_bvalid",    bvalid, 1);
        check("s1_bresp",     bresp,  0);
        step();
        check("s1_bvalid_off", bvalid,  0);
        check("s1_awready_up", awready, 1);
        check("s1_wready_up",  wready,  1);

        // W first, AW four cycles later; W valid kept high with other data meanwhile.
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
        step();
        wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            check("s2_wready_low", wready,  0);
            check("s2_awready_hi", awready, 1);
            check("s2_no_wr_en",   wr_en,   0);
            if (i < 3) step();
        end
        awaddr = 8'h3C; awvalid = 1'b1;
        step();
        idle_inputs();
        check("s2_wr_en",   wr_en,   1);
        check("s2_wr_addr", wr_addr, 15);
        check("s2_wr_data", wr_data, 32'h12345678);
        check("s2_wr_strb", wr_strb, 4'h3);
        step();
        check("s2_bvalid", bvalid, 1);
        check("s2_bresp",  bresp,  0);
        step();
        check("s2_done", bvalid, 0);

        // Out-of-range index 16 yields SLVERR and no write strobe.
        awaddr = 8'h40; awvalid = 1'b1;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        step();
        idle_inputs();
        check("s3_no_wr_en", wr_en, 0);
        step();
        check("s3_no_wr_en2", wr_en,  0);
        check("s3_bvalid",    bvalid, 1);
        check("s3_bresp",     bresp,  2'b10);
        step();
        check("s3_done", bvalid, 0);

        // Unaligned address with all-zero strobe still writes word 2.
        awaddr = 8'h0B; awvalid = 1'b1;
        wdata = 32'h0000A5A5; wstrb = 4'h0; wvalid = 1'b1;
        step();
        idle_inputs();
        check("s4_wr_en",   wr_en,   1);
        check("s4_wr_addr", wr_addr, 2);
        check("s4_wr_strb", wr_strb, 4'h0);
        step();
        check("s4_bresp", bresp, 0);
        step();

        // Backpressure on B for 7 cycles; new valids must not be taken.
        bready = 1'b0;
        awaddr = 8'h44; awvalid = 1'b1;
        wdata = 32'h55AA55AA; wstrb = 4'h5; wvalid = 1'b1;
        step();
        awaddr = 8'h04; wdata = 32'h11111111; wstrb = 4'hF;
        check("s5_no_wr_en", wr_en, 0);
        step();
        for (int i = 0; i < 7; i++) begin
            check("s5_bvalid_hold", bvalid,  1);
            check("s5_bresp_hold",  bresp,   2'b10);
            check("s5_awready_low", awready, 0);
            check("s5_wready_low",  wready,  0);
            check("s5_addr_hold",   wr_addr, 17);
            check("s5_data_hold",   wr_data, 32'h55AA55AA);
            check("s5_wr_en_low",   wr_en,   0);
            step();
        end
        idle_inputs();
        check("s5_still_valid", bvalid, 1);
        bready = 1'b1;
        step();
        check("s5_done",    bvalid,  0);
        check("s5_awready", awready, 1);
        check("s5_wr_en",   wr_en,   0);

        // Reset pulse while in RESP aborts the transaction.
        bready = 1'b0;
        awaddr = 8'h10; awvalid = 1'b1;
        wdata = 32'h87654321; wstrb = 4'hF; wvalid = 1'b1;
        step();
        idle_inputs();
        check("s6_wr_en", wr_en, 1);
        step();
        check("s6_bvalid", bvalid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("s6_rst_bvalid",  bvalid,  0);
        check("s6_rst_awready", awready, 0);
        check("s6_rst_wr_en",   wr_en,   0);
        check("s6_rst_wr_data", wr_data, 0);
        step();
        check("s6_awready", awready, 1);
        check("s6_wready",  wready,  1);
        check("s6_bvalid2", bvalid,  0);
        check("s6_wr_en2",  wr_en,   0);
        bready = 1'b1;

        // Back-to-back writes to indices 0,1,2 with valids held high.
        awvalid = 1'b1; wvalid = 1'b1;
        awaddr = 8'h00; wdata = 32'hA0000000; wstrb = 4'h1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("s7_wr_en",   wr_en,   1);
            check("s7_wr_addr", wr_addr, 6'(i));
            check("s7_wr_data", wr_data, 32'hA0000000 + 32'(i));
            check("s7_wr_strb", wr_strb, 4'(1 << i));
            if (i < 2) begin
                awaddr = 8'(4 * (i + 1));
                wdata  = 32'hA0000000 + 32'(i + 1);
                wstrb  = 4'(1 << (i + 1));
            end else begin
                idle_inputs();
            end
            step();
            check("s7_gap1_wr_en", wr_en,  0);
            check("s7_bvalid",     bvalid, 1);
            step();
            check("s7_gap2_wr_en", wr_en,  0);
            check("s7_ready",      awready, 1);
            step();
        end
        check("s7_tail_wr_en", wr_en,  0);
        check("s7_tail_bvalid", bvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
